// File: rtl/mem_pkg.sv
// Shared types for the memory arbiter: arbitration modes,
// read-response owner tags and default RAM geometry.
package mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    STARVED = 2'd1,
    HALTED  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / debug) arbiter for a single-port RAM.
// Ports: cpu_* and dbg_* req/gnt/rvalid/rdata, cpu_halted,
// mem_* RAM request, mem_rdata (1-cycle latency), mode.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              cpu_halted,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        mode
);

  localparam logic [3:0] LIM = 4'(STARVE_MAX);

  mode_t      r_mode;
  owner_t     r_owner;
  logic [3:0] r_starve_cnt;

  logic       w_cpu_win;
  logic       w_dbg_win;
  logic       w_dbg_wait;
  logic [3:0] w_cnt_nxt;

  // STARVED and HALTED both hand priority to debug.
  always_comb begin
    w_cpu_win = 1'b0;
    w_dbg_win = 1'b0;
    if (!reset) begin
      case (r_mode)
        STARVED, HALTED: begin
          w_dbg_win = dbg_req;
          w_cpu_win = cpu_req & ~dbg_req;
        end
        default: begin
          w_cpu_win = cpu_req;
          w_dbg_win = dbg_req & ~cpu_req;
        end
      endcase
    end
  end

  assign cpu_gnt = w_cpu_win;
  assign dbg_gnt = w_dbg_win;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (w_cpu_win) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end else if (w_dbg_win) begin
      mem_addr  = dbg_addr;
      mem_we    = dbg_we;
      mem_wdata = dbg_wdata;
    end
  end

  assign w_dbg_wait = dbg_req & ~w_dbg_win;

  always_comb begin
    w_cnt_nxt = 4'd0;
    if (w_dbg_wait) begin
      if (r_starve_cnt >= LIM) w_cnt_nxt = LIM;
      else w_cnt_nxt = r_starve_cnt + 4'd1;
    end
  end

  // Mode switches on the edge where the denial count
  // reaches the limit, so debug wins on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode       <= NORMAL;
      r_starve_cnt <= 4'd0;
      r_owner      <= OWN_NONE;
    end else begin
      if (w_cpu_win && !cpu_we)
        r_owner <= OWN_CPU;
      else if (w_dbg_win && !dbg_we)
        r_owner <= OWN_DBG;
      else
        r_owner <= OWN_NONE;

      if (cpu_halted) begin
        r_mode       <= HALTED;
        r_starve_cnt <= 4'd0;
      end else begin
        r_starve_cnt <= w_cnt_nxt;
        case (r_mode)
          NORMAL:
            if (w_cnt_nxt >= LIM) r_mode <= STARVED;
          STARVED:
            if (w_dbg_win || !dbg_req) r_mode <= NORMAL;
          default:
            r_mode <= NORMAL;
        endcase
      end
    end
  end

  // A response pending across a reset cycle is dropped.
  assign cpu_rvalid = !reset && (r_owner == OWN_CPU);
  assign dbg_rvalid = !reset && (r_owner == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  assign mode       = r_mode;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus random
// traffic checked every cycle against a reference model.
module tb_mem_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        dbg_req, dbg_we;
  logic [7:0]  dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [15:0] dbg_rdata;
  logic        cpu_halted;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [1:0]  mode;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .ADDR_W(8), .DATA_W(16), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .cpu_halted(cpu_halted),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mode(mode)
  );

  always #5 clk = ~clk;

  // RAM fixture with a side load port used during reset.
  logic [15:0] ram [256];
  logic        ld_we;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;

  always @(posedge clk) begin
    if (ld_we) ram[ld_addr] <= ld_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model state (mode: 0 normal, 1 starved,
  // 2 halted; owner: 0 none, 1 cpu, 2 dbg).
  logic [15:0] mm [256];
  int          m_mode, m_wait, m_own;
  logic [15:0] m_pd;
  bit          e_cg, e_dg;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic settle();
    logic [7:0]  ea;
    logic [15:0] ed;
    bit          ew;
    bit          dbg_first;
    @(negedge clk);
    e_cg = 0;
    e_dg = 0;
    dbg_first = (m_mode == 1) || (m_mode == 2);
    if (!reset) begin
      if (dbg_first && dbg_req) e_dg = 1;
      else if (cpu_req) e_cg = 1;
      else if (dbg_req) e_dg = 1;
    end
    ea = 0; ed = 0; ew = 0;
    if (e_cg) begin
      ea = cpu_addr; ed = cpu_wdata; ew = cpu_we;
    end
    if (e_dg) begin
      ea = dbg_addr; ed = dbg_wdata; ew = dbg_we;
    end
    chk("cpu_gnt", cpu_gnt, e_cg);
    chk("dbg_gnt", dbg_gnt, e_dg);
    chk("mem_addr", mem_addr, ea);
    chk("mem_we", mem_we, ew);
    chk("mem_wdata", mem_wdata, ed);
    chk("cpu_rvalid", cpu_rvalid,
        !reset && m_own == 1);
    chk("dbg_rvalid", dbg_rvalid,
        !reset && m_own == 2);
    chk("cpu_rdata", cpu_rdata,
        (!reset && m_own == 1) ? m_pd : 16'h0);
    chk("dbg_rdata", dbg_rdata,
        (!reset && m_own == 2) ? m_pd : 16'h0);
    chk("mode", mode, m_mode);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_mode = 0;
      m_wait = 0;
      m_own  = 0;
    end else begin
      m_own = 0;
      if (e_cg && !cpu_we) begin
        m_own = 1; m_pd = mm[cpu_addr];
      end
      if (e_dg && !dbg_we) begin
        m_own = 2; m_pd = mm[dbg_addr];
      end
      if (e_cg && cpu_we) mm[cpu_addr] = cpu_wdata;
      if (e_dg && dbg_we) mm[dbg_addr] = dbg_wdata;
      if (dbg_req && !e_dg)
        m_wait = (m_wait + 1 > SM) ? SM : m_wait + 1;
      else
        m_wait = 0;
      if (cpu_halted) begin
        m_mode = 2;
        m_wait = 0;
      end else if (m_mode == 2) m_mode = 0;
      else if (m_mode == 0 && m_wait >= SM) m_mode = 1;
      else if (m_mode == 1 && (e_dg || !dbg_req))
        m_mode = 0;
    end
    #1;
  endtask

  task automatic creq(bit r, bit w, logic [7:0] a,
                      logic [15:0] d);
    cpu_req = r; cpu_we = w;
    cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dreq(bit r, bit w, logic [7:0] a,
                      logic [15:0] d);
    dbg_req = r; dbg_we = w;
    dbg_addr = a; dbg_wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    cpu_halted = 0;
    ld_we = 0; ld_addr = 0; ld_data = 0;
    creq(0, 0, 0, 0);
    dreq(0, 0, 0, 0);
    m_mode = 0; m_wait = 0; m_own = 0; m_pd = 0;
    repeat (2) @(posedge clk);
    #1;

    // Load RAM while in reset; reset outputs checked.
    for (int i = 0; i < 32; i++) begin
      ld_we = 1;
      ld_addr = 8'(i);
      ld_data = 16'($urandom);
      mm[i] = ld_data;
      if (i == 3) begin
        creq(1, 1, 8'h05, 16'hFFFF);
        dreq(1, 1, 8'h06, 16'hEEEE);
      end
      if (i == 5) begin
        creq(0, 0, 0, 0);
        dreq(0, 0, 0, 0);
      end
      settle();
      tick();
    end
    ld_we = 0;
    chk("rst_starve_cnt", dut.r_starve_cnt, 0);
    reset = 0;

    // CPU-only write then read of 0x0F.
    creq(1, 1, 8'h0F, 16'h0004);
    settle();
    chk("t1_wr_gnt", cpu_gnt, 1);
    tick();
    creq(1, 0, 8'h0F, 0);
    settle();
    chk("t1_rd_gnt", cpu_gnt, 1);
    tick();
    creq(0, 0, 0, 0);
    settle();
    chk("t1_rvalid", cpu_rvalid, 1);
    chk("t1_rdata", cpu_rdata, 16'h0004);
    chk("t1_dbg_rvalid", dbg_rvalid, 0);
    tick();

    // Starvation guard under continuous CPU traffic.
    creq(1, 0, 8'h05, 0);
    dreq(1, 0, 8'h06, 0);
    for (int k = 0; k < SM; k++) begin
      settle();
      chk("t2_denied", dbg_gnt, 0);
      tick();
    end
    settle();
    chk("t2_mode_starved", mode, 1);
    chk("t2_dbg_gnt", dbg_gnt, 1);
    chk("t2_cpu_gnt", cpu_gnt, 0);
    tick();
    dreq(0, 0, 0, 0);
    settle();
    chk("t2_mode_normal", mode, 0);
    tick();
    creq(0, 0, 0, 0);

    // Halted CPU: debug has priority.
    cpu_halted = 1;
    settle();
    tick();
    creq(1, 0, 8'h01, 0);
    dreq(1, 1, 8'h14, 16'h0352);
    settle();
    chk("t3_dbg_gnt", dbg_gnt, 1);
    chk("t3_cpu_gnt", cpu_gnt, 0);
    chk("t3_mode", mode, 2);
    tick();
    dreq(1, 0, 8'h14, 0);
    settle();
    chk("t3_rd_gnt", dbg_gnt, 1);
    tick();
    dreq(0, 0, 0, 0);
    settle();
    chk("t3_rvalid", dbg_rvalid, 1);
    chk("t3_rdata", dbg_rdata, 16'h0352);
    chk("t3_cpu_gnt2", cpu_gnt, 1);
    tick();
    cpu_halted = 0;
    creq(0, 0, 0, 0);
    settle();
    tick();
    settle();
    chk("t3_mode_back", mode, 0);
    tick();

    // Alternating reads route to their own requester.
    creq(1, 1, 8'h10, 16'h0032);
    settle();
    tick();
    creq(1, 1, 8'h11, 16'h00C8);
    settle();
    tick();
    creq(1, 0, 8'h10, 0);
    settle();
    chk("t4_cpu_gnt", cpu_gnt, 1);
    tick();
    creq(0, 0, 0, 0);
    dreq(1, 0, 8'h11, 0);
    settle();
    chk("t4_dbg_gnt", dbg_gnt, 1);
    chk("t4_cpu_rvalid", cpu_rvalid, 1);
    chk("t4_cpu_rdata", cpu_rdata, 16'h0032);
    chk("t4_dbg_rv0", dbg_rvalid, 0);
    tick();
    dreq(0, 0, 0, 0);
    settle();
    chk("t4_dbg_rvalid", dbg_rvalid, 1);
    chk("t4_dbg_rdata", dbg_rdata, 16'h00C8);
    chk("t4_cpu_rv0", cpu_rvalid, 0);
    chk("t4_cpu_rd0", cpu_rdata, 0);
    tick();

    // Reset right after a granted read.
    creq(1, 0, 8'h0F, 0);
    settle();
    tick();
    reset = 1;
    creq(1, 1, 8'h02, 16'h1234);
    settle();
    chk("t5_rvalid", cpu_rvalid, 0);
    chk("t5_mem_we", mem_we, 0);
    chk("t5_gnt", cpu_gnt, 0);
    tick();
    reset = 0;
    creq(0, 0, 0, 0);
    settle();
    chk("t5_rvalid2", cpu_rvalid, 0);
    chk("t5_mode", mode, 0);
    chk("t5_starve", dut.r_starve_cnt, 0);
    tick();

    // Uncontended write then read-back.
    creq(1, 1, 8'h14, 16'hBADD);
    settle();
    chk("t6_mem_we", mem_we, 1);
    chk("t6_mem_addr", mem_addr, 8'h14);
    tick();
    creq(0, 0, 0, 0);
    settle();
    chk("t6_we_off", mem_we, 0);
    chk("t6_no_rvalid", cpu_rvalid, 0);
    tick();
    creq(1, 0, 8'h14, 0);
    settle();
    tick();
    creq(0, 0, 0, 0);
    settle();
    chk("t6_rdata", cpu_rdata, 16'hBADD);
    tick();

    // Random traffic; requests held until granted.
    for (int n = 0; n < 400; n++) begin
      if (!cpu_req || e_cg)
        creq($urandom_range(0, 3) != 0,
             1'($urandom), 8'($urandom_range(0, 31)),
             16'($urandom));
      if (!dbg_req || e_dg)
        dreq($urandom_range(0, 2) == 0,
             1'($urandom), 8'($urandom_range(0, 31)),
             16'($urandom));
      if ($urandom_range(0, 24) == 0)
        cpu_halted = !cpu_halted;
      reset = ($urandom_range(0, 99) == 0);
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port 256x16 RAM (`MEM`) between the CPU's load/store/fetch path and a debug/loader port used to inspect or patch memory. It sits between `CPU` and `MEM` in the top level. It selects one access per cycle, drives the RAM address, write-enable and write-data, and routes one-cycle-latency read data back to the requester that issued the read. Fairness comes from CPU priority, a starvation guard for the debug port, and debug priority while the CPU is halted.

## Interface
Parameters:
- `ADDR_W`, 8: RAM address width.
- `DATA_W`, 16: RAM word width.
- `STARVE_MAX`, 4: number of consecutive cycles a pending debug request may be denied before it is forced through (range 1..15).

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: rising-edge clock; the same clock as `CPU` and `MEM`.
- `reset` input 1: synchronous, active-high.
- `cpu_req`, `cpu_we` input 1: CPU request valid; write when 1.
- `cpu_addr` input `ADDR_W`, `cpu_wdata` input `DATA_W`: CPU request address and write data.
- `cpu_gnt` output 1: CPU request accepted this cycle.
- `cpu_rvalid` output 1, `cpu_rdata` output `DATA_W`: read response for the CPU.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`: debug request; same meaning and widths as the CPU request.
- `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: debug grant and read response; same meaning and widths as the CPU outputs.
- `cpu_halted` input 1: CPU is in the HALT state (drives LEDR[8]).
- `mem_addr` output `ADDR_W`, `mem_we` output 1, `mem_wdata` output `DATA_W`: RAM request.
- `mem_rdata` input `DATA_W`: RAM read data, registered, valid the cycle after the address is presented.
- `mode` output 2: current arbitration state, for debug visibility.

## Operation
- Handshake:
  - A requester holds `*_req` and its fields stable until it sees `*_gnt`=1.
  - A transfer happens in a cycle with `req`&`gnt`.
  - `gnt` is combinational from the current `req` inputs and the current state.
  - At most one `gnt` is asserted per cycle.
- RAM drive:
  - `mem_addr`, `mem_we` and `mem_wdata` are combinational copies of the winner's fields.
  - With no winner, `mem_we`=0, `mem_addr`=0 and `mem_wdata`=0.
- State machine `mode`, with three states:
  - NORMAL=0: CPU wins whenever `cpu_req`=1; debug wins only when `cpu_req`=0.
  - STARVED=1: debug wins if `dbg_req`=1, even when `cpu_req`=1.
  - HALTED=2: debug wins whenever `dbg_req`=1; the CPU wins only when `dbg_req`=0.
- State transitions:
  - Any state goes to HALTED when `cpu_halted`=1. This has highest precedence.
  - HALTED goes to NORMAL when `cpu_halted`=0.
  - NORMAL goes to STARVED when `starve_cnt` reaches `STARVE_MAX`.
  - STARVED goes to NORMAL after a debug grant, or when `dbg_req` drops.
- Starvation counter `starve_cnt` (4 bits, internal):
  - Increments on each cycle where `dbg_req`=1 and `dbg_gnt`=0.
  - Saturates at `STARVE_MAX`.
  - Clears on a debug grant, when `dbg_req`=0, or when entering HALTED.
- Read responses:
  - A granted read registers an owner tag.
  - The next cycle, the owner's `rvalid`=1 and its `rdata`=`mem_rdata`.
  - The non-owner's `rdata` is 0.
  - Granted writes produce no `rvalid`.
- Back-to-back reads from alternating requesters are legal; each response goes to its own requester.

## Timing
- Reset values:
  - `mode`=NORMAL, `starve_cnt`=0, owner tag cleared.
  - `cpu_rvalid`=0, `dbg_rvalid`=0.
  - During a cycle with `reset`=1, both `gnt`s and `mem_we` are forced to 0.
- Latency:
  - Grant is 0 cycles after request when uncontended.
  - Read data arrives 1 cycle after grant.
  - A write commits at the granting clock edge.
- Throughput: one access per cycle.
- A pending debug request under continuous CPU traffic is granted no later than cycle `STARVE_MAX`+1 after `dbg_req` rises.
- Reset mid-read: a response due in the cycle after reset is dropped, so `rvalid` stays 0.
- A `cpu_halted` rise in the same cycle as a STARVED grant: the grant completes, and the next state is HALTED.

## Structure
- Shared package `mem_pkg` holds:
  - the `mode_t` enum (NORMAL, STARVED, HALTED);
  - the owner enum (OWN_NONE, OWN_CPU, OWN_DBG);
  - `ADDR_W`/`DATA_W` defaults.
- Single module; no sub-module is needed. The starvation counter and the mode FSM stay in one always block, and the grant logic goes in one combinational block.

## Test plan
- CPU only, reads mem[0x0F] after loading 0x0004 → `cpu_gnt`=1 in the same cycle; next cycle `cpu_rvalid`=1, `cpu_rdata`=0x0004, and `dbg_rvalid`=0.
- Continuous `cpu_req`, `dbg_req` raised at cycle T, `STARVE_MAX`=4 → `dbg_gnt`=0 for T..T+3; `mode`=STARVED and `dbg_gnt`=1 at T+4; `mode`=NORMAL at T+5.
- `cpu_halted`=1 with both requesting; debug writes 0x0352 to 0x14 → `dbg_gnt`=1, `cpu_gnt`=0, `mode`=HALTED; a later debug read of 0x14 returns 0x0352.
- Alternating grants: CPU read 0x10 (0x0032), then debug read 0x11 (0x00C8) → `cpu_rdata`=0x0032 and `dbg_rdata`=0x00C8 on consecutive cycles, each with only its own `rvalid`.
- `reset` asserted in the cycle after a granted read → no `rvalid`; `mode`=NORMAL; `starve_cnt`=0; `mem_we`=0 during reset.
- Write with no contention, CPU writes 0xBADD to 0x14 → `mem_we`=1 for one cycle, no `rvalid`; a subsequent read returns 0xBADD.
